// File: rtl/axi_lite_mem_arbiter_pkg.sv
// Shared types and bus constants for the IFU/LSU AXI-lite memory arbiter.
package axi_arb_pkg;

    localparam int unsigned AXI_ADDR_BUS = 32;
    localparam int unsigned AXI_DATA_BUS = 32;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;

    typedef enum logic [1:0] {IDLE, RD0, RD1, WR1} arb_state_e;
    typedef enum logic       {M0, M1}              mst_id_e;

endpackage

// File: rtl/axi_lite_mem_arbiter_rr_arb2.sv
// Two-requester round-robin picker: on a tie the requester not granted last time wins.
module rr_arb2
    import axi_arb_pkg::*;
(
    input  logic [1:0] req,
    input  mst_id_e    last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_gnt == M0) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/axi_lite_mem_arbiter.sv
// Shares one AXI-lite SRAM slave between IFU (m0, read-only) and LSU (m1, read/write),
// one outstanding transaction at a time, grant held until the R/B handshake.
module axi_lite_mem_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = AXI_ADDR_BUS,
    parameter int unsigned DATA_W = AXI_DATA_BUS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    output logic [1:0]          m1_bresp,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic                s_arvalid,
    input  logic                s_arready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rvalid,
    output logic                s_rready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wvalid,
    input  logic                s_wready,
    input  logic [1:0]          s_bresp,
    input  logic                s_bvalid,
    output logic                s_bready
);

    arb_state_e state;
    mst_id_e    last_gnt;
    logic       ar_done, aw_done, w_done;
    logic [1:0] req, gnt;
    logic       rd0, rd1, wr;
    logic       ar_hs, r_hs, aw_hs, w_hs, b_hs, b_en;

    assign req = {m1_arvalid | m1_awvalid, m0_arvalid};

    rr_arb2 u_rr (
        .req      (req),
        .last_gnt (last_gnt),
        .gnt      (gnt)
    );

    assign rd0 = (state == RD0);
    assign rd1 = (state == RD1);
    assign wr  = (state == WR1);

    assign ar_hs = s_arvalid & s_arready;
    assign r_hs  = s_rvalid & s_rready;
    assign aw_hs = s_awvalid & s_awready;
    assign w_hs  = s_wvalid & s_wready;
    assign b_hs  = s_bvalid & s_bready;
    // B opens in the cycle the last of AW/W completes so all three can fire together.
    assign b_en  = wr & (aw_done | aw_hs) & (w_done | w_hs);

    // Read channels; ar_done stops the address being re-issued while waiting on R.
    assign s_araddr   = rd0 ? m0_araddr : (rd1 ? m1_araddr : '0);
    assign s_arvalid  = ((rd0 & m0_arvalid) | (rd1 & m1_arvalid)) & ~ar_done;
    assign m0_arready = rd0 & ~ar_done & s_arready;
    assign m1_arready = rd1 & ~ar_done & s_arready;
    assign s_rready   = (rd0 & m0_rready) | (rd1 & m1_rready);
    assign m0_rvalid  = rd0 & s_rvalid;
    assign m1_rvalid  = rd1 & s_rvalid;
    assign m0_rdata   = rd0 ? s_rdata : '0;
    assign m1_rdata   = rd1 ? s_rdata : '0;
    assign m0_rresp   = rd0 ? s_rresp : '0;
    assign m1_rresp   = rd1 ? s_rresp : '0;

    // Write channels
    assign s_awaddr   = wr ? m1_awaddr : '0;
    assign s_awvalid  = wr & m1_awvalid & ~aw_done;
    assign m1_awready = wr & ~aw_done & s_awready;
    assign s_wdata    = wr ? m1_wdata : '0;
    assign s_wstrb    = wr ? m1_wstrb : '0;
    assign s_wvalid   = wr & m1_wvalid & ~w_done;
    assign m1_wready  = wr & ~w_done & s_wready;
    assign s_bready   = b_en & m1_bready;
    assign m1_bvalid  = b_en & s_bvalid;
    assign m1_bresp   = b_en ? s_bresp : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= M1;
            ar_done  <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt[0]) begin
                        state    <= RD0;
                        last_gnt <= M0;
                    end else if (gnt[1]) begin
                        state    <= m1_arvalid ? RD1 : WR1;
                        last_gnt <= M1;
                    end
                end
                RD0, RD1: begin
                    if (r_hs) begin
                        state   <= IDLE;
                        ar_done <= 1'b0;
                    end else if (ar_hs) begin
                        ar_done <= 1'b1;
                    end
                end
                WR1: begin
                    if (b_hs) begin
                        state   <= IDLE;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        if (aw_hs) aw_done <= 1'b1;
                        if (w_hs)  w_done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Scoreboard bench for axi_lite_mem_arbiter with a configurable behavioural SRAM slave.
module tb_axi_lite_mem_arbiter;
    import axi_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_araddr, m1_araddr, m1_awaddr, m1_wdata;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp, m1_bresp;
    logic [3:0]  m1_wstrb, s_wstrb;
    logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
    logic [1:0]  s_rresp, s_bresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;

    // Slave configuration and state
    logic        zl, aw_en, w_en, eager;
    logic        rpend, got_aw, got_w, bpend;
    logic [31:0] raddr;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [33:0] q0[$], q1[$];
    logic [31:0] qaw[$];
    logic [35:0] qw[$];
    logic [1:0]  qb[$];
    int          ord[$];
    int          aw_pulses = 0, w_pulses = 0, early_b = 0;
    logic        aw_prev = 1'b0, w_prev = 1'b0;

    always #5 clk = ~clk;

    axi_lite_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [1:0] rs_fn(input logic [31:0] a);
        return (a[31:20] == 12'hBAD) ? 2'b10 : RESP_OKAY;
    endfunction

    // Zero-latency mode answers R combinationally in the AR cycle; otherwise one R per AR, registered.
    assign s_arready = zl ? 1'b1 : !rpend;
    assign s_rvalid  = zl ? s_arvalid : rpend;
    assign s_rdata   = rd_fn(zl ? s_araddr : raddr);
    assign s_rresp   = rs_fn(zl ? s_araddr : raddr);
    assign s_awready = aw_en;
    assign s_wready  = w_en;
    assign s_bvalid  = bpend;
    assign s_bresp   = RESP_OKAY;

    always @(posedge clk) begin
        if (rst) begin
            rpend <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0; bpend <= 1'b0; raddr <= '0;
        end else begin
            if (!zl && s_arvalid && s_arready) begin
                rpend <= 1'b1;
                raddr <= s_araddr;
            end else if (rpend && s_rready) begin
                rpend <= 1'b0;
            end
            if (bpend && s_bready) begin
                bpend <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0;
            end else begin
                if (s_awvalid && s_awready) got_aw <= 1'b1;
                if (s_wvalid && s_wready)   got_w  <= 1'b1;
                // Eager mode raises B after W alone, so the arbiter must hold it back until AW.
                if ((got_w || (s_wvalid && s_wready)) &&
                    (eager || got_aw || (s_awvalid && s_awready)))
                    bpend <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (m0_arready) ord.push_back(0);
            if (m1_arready) ord.push_back(1);
            if (m0_rvalid && m0_rready) begin
                if (q0.size() == 0) check("m0_r_extra", q0.size(), 1);
                else check("m0_r", {m0_rdata, m0_rresp}, q0.pop_front());
            end
            if (m1_rvalid && m1_rready) begin
                if (q1.size() == 0) check("m1_r_extra", q1.size(), 1);
                else check("m1_r", {m1_rdata, m1_rresp}, q1.pop_front());
            end
            if (s_awvalid && s_awready) begin
                if (qaw.size() == 0) check("aw_extra", qaw.size(), 1);
                else check("s_aw", s_awaddr, qaw.pop_front());
            end
            if (s_wvalid && s_wready) begin
                if (qw.size() == 0) check("w_extra", qw.size(), 1);
                else check("s_w", {s_wdata, s_wstrb}, qw.pop_front());
            end
            if (m1_bvalid && m1_bready) begin
                if (qb.size() == 0) check("b_extra", qb.size(), 1);
                else check("m1_b", m1_bresp, qb.pop_front());
            end
            if (m1_bvalid && !((got_aw || (s_awvalid && s_awready)) &&
                               (got_w || (s_wvalid && s_wready))))
                early_b <= early_b + 1;
        end
        aw_prev <= s_awvalid;
        w_prev  <= s_wvalid;
        if (s_awvalid && !aw_prev) aw_pulses <= aw_pulses + 1;
        if (s_wvalid && !w_prev)   w_pulses  <= w_pulses + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int id, input logic [31:0] a, output int lat);
        lat = 0;
        if (id == 0) q0.push_back({rd_fn(a), rs_fn(a)});
        else         q1.push_back({rd_fn(a), rs_fn(a)});
        tick();
        if (id == 0) begin m0_araddr = a; m0_arvalid = 1'b1; end
        else         begin m1_araddr = a; m1_arvalid = 1'b1; end
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if ((id == 0) ? m0_arready : m1_arready) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) check("ar_timeout", lat, 1);
        tick();
        if (id == 0) begin m0_arvalid = 1'b0; m0_araddr = '0; end
        else         begin m1_arvalid = 1'b0; m1_araddr = '0; end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic aw_ok, w_ok;
        qaw.push_back(a);
        qw.push_back({d, s});
        qb.push_back(RESP_OKAY);
        tick();
        m1_awaddr = a; m1_awvalid = 1'b1;
        m1_wdata  = d; m1_wstrb = s; m1_wvalid = 1'b1;
        aw_ok = 1'b0; w_ok = 1'b0;
        for (int i = 0; i < 40 && !(aw_ok && w_ok); i++) begin
            @(negedge clk);
            if (m1_awready) aw_ok = 1'b1;
            if (m1_wready)  w_ok  = 1'b1;
            tick();
            if (aw_ok) m1_awvalid = 1'b0;
            if (w_ok)  m1_wvalid  = 1'b0;
        end
        if (!(aw_ok && w_ok)) check("wr_timeout", {aw_ok, w_ok}, 2'b11);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((q0.size() + q1.size() + qaw.size() + qw.size() + qb.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check({tag, "_drain"}, q0.size() + q1.size() + qaw.size() + qw.size() + qb.size(), 0);
        tick();
    endtask

    task automatic chk_order(input string tag, input int first);
        if (ord.size() != 2) check({tag, "_n"}, ord.size(), 2);
        else begin
            check({tag, "_first"}, ord[0], first);
            check({tag, "_second"}, ord[1], 1 - first);
        end
        ord.delete();
    endtask

    task automatic tie(input string tag, input int first);
        int l0, l1;
        ord.delete();
        fork
            rd(0, 32'h8000_0010, l0);
            rd(1, 32'h1000_0020, l1);
        join
        wait_drain(tag);
        chk_order(tag, first);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        check({tag, "_valids"},
              {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready, m0_arready, m0_rvalid,
               m1_arvalid & m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid}, '0);
        check({tag, "_addr"}, {s_araddr, s_awaddr}, '0);
    endtask

    initial begin
        int lat, l0, l1, aw0, w0, stall_bad, n;
        rst = 1'b1;
        m0_araddr = '0; m0_arvalid = 1'b1; m0_rready = 1'b1;
        m1_araddr = '0; m1_arvalid = 1'b0; m1_rready = 1'b1;
        m1_awaddr = '0; m1_awvalid = 1'b0; m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 1'b0;
        m1_bready = 1'b1;
        zl = 1'b1; aw_en = 1'b1; w_en = 1'b1; eager = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk_quiet("reset");
        m0_arvalid = 1'b0;
        tick();
        rst = 1'b0;

        // Single IFU read through a zero-latency slave
        rd(0, 32'h8000_0000, lat);
        check("ifu_ar_lat", lat, 2);
        wait_drain("ifu_read");
        @(negedge clk);
        chk_quiet("idle_after_rd");

        // IFU was granted last, so the tie goes to the LSU
        tie("tie_after_ifu", 1);
        do_reset();
        tie("tie_after_reset", 0);
        tie("tie_alternate", 0);

        // LSU write: W accepted two cycles before AW, slave raises B early
        aw_en = 1'b0; eager = 1'b1;
        aw0 = aw_pulses; w0 = w_pulses;
        fork
            wr(32'h0000_1000, 32'hDEADBEEF, 4'b0011);
            begin
                n = 0;
                while (!(m1_wready) && n < 40) begin @(negedge clk); n++; end
                if (n >= 40) check("w_wait_timeout", n, 0);
                tick();
                tick();
                aw_en = 1'b1;
            end
        join
        wait_drain("lsu_write");
        check("aw_pulses", aw_pulses - aw0, 1);
        check("w_pulses", w_pulses - w0, 1);
        check("early_bvalid", early_b, 0);
        eager = 1'b0;

        // Backpressure: IFU holds rready low, LSU read must stall
        zl = 1'b0; m0_rready = 1'b0; stall_bad = 0;
        ord.delete();
        fork
            rd(0, 32'h8000_0040, l0);
            begin tick(); rd(1, 32'h1000_0040, l1); end
            begin
                n = 0;
                while (!m0_rvalid && n < 40) begin @(negedge clk); n++; end
                if (n >= 40) check("bp_rvalid_timeout", n, 0);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    if (m1_arready || !m0_rvalid) stall_bad++;
                end
                tick();
                m0_rready = 1'b1;
            end
        join
        wait_drain("backpressure");
        check("bp_stall", stall_bad, 0);
        chk_order("bp_order", 0);

        // Error response passes through and the arbiter recovers
        zl = 1'b1;
        rd(1, 32'hBAD0_0000, lat);
        wait_drain("err_read");
        rd(0, 32'h8000_0100, lat);
        wait_drain("after_err");

        // Reset in WR1 after AW only, then a clean write
        w_en = 1'b0;
        qaw.push_back(32'h0000_3000);
        tick();
        m1_awaddr = 32'h0000_3000; m1_awvalid = 1'b1;
        m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'hF; m1_wvalid = 1'b1;
        n = 0;
        while (!m1_awready && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) check("rst_aw_timeout", n, 0);
        tick();
        m1_awvalid = 1'b0;
        tick();
        rst = 1'b1;
        m1_wvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_quiet("rst_mid_wr");
        tick();
        rst = 1'b0;
        w_en = 1'b1;
        wr(32'h0000_2000, 32'h1234_5678, 4'b1111);
        wait_drain("write_after_rst");
        @(negedge clk);
        chk_quiet("final_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
